// File: rtl/stream_test_sequencer.sv
// Drives a streaming UUT through reset, then captures NUM_BLOCKS output blocks on
// end_uut_i rising edges with a valid/ready handoff. Optional macro: SEQ_CYCLE_COUNT_EN.
module stream_test_sequencer #(
  parameter int IN1_W      = 80,
  parameter int IN2_W      = 80,
  parameter int OUT_W      = 64,
  parameter int NUM_BLOCKS = 4,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IN1_W-1:0] vec1_i,
  input  logic [IN2_W-1:0] vec2_i,
  input  logic             vec_valid_i,
  output logic             rst_uut_o,
  output logic [IN1_W-1:0] input_to_uut_1_o,
  output logic [IN2_W-1:0] input_to_uut_2_o,
  output logic             next_data_o,
  input  logic             end_uut_i,
  input  logic [OUT_W-1:0] uut_data_i,
  output logic             result_valid_o,
  output logic [OUT_W-1:0] result_data_o,
  output logic [7:0]       result_idx_o,
  input  logic             result_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [31:0]      cycle_count_o,
  input  logic [1:0]       sw_debug_i,
  output logic [31:0]      debug_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UUT_RST = 3'd1,
    S_RUN     = 3'd2,
    S_HOLD    = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);
  localparam logic [7:0]  IDX_LAST = 8'(NUM_BLOCKS - 1);

  state_t      state;
  logic [31:0] rst_cnt;
  logic [31:0] run_cnt;
  logic        end_prev;
  logic        end_rise;

  // end_prev tracks end_uut_i in every state, so a flag already high on RUN entry is no edge
  assign end_rise = end_uut_i & ~end_prev;
  assign busy_o   = (state == S_UUT_RST) || (state == S_RUN) || (state == S_HOLD);

`ifdef SEQ_CYCLE_COUNT_EN
  logic [31:0] cycle_count_q;
  assign cycle_count_o = cycle_count_q;
`else
  assign cycle_count_o = 32'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      rst_uut_o        <= 1'b1;
      input_to_uut_1_o <= '0;
      input_to_uut_2_o <= '0;
      next_data_o      <= 1'b0;
      result_valid_o   <= 1'b0;
      result_data_o    <= '0;
      result_idx_o     <= '0;
      done_o           <= 1'b0;
      timeout_o        <= 1'b0;
      rst_cnt          <= '0;
      run_cnt          <= '0;
      end_prev         <= 1'b0;
`ifdef SEQ_CYCLE_COUNT_EN
      cycle_count_q    <= '0;
`endif
    end else begin
      end_prev    <= end_uut_i;
      next_data_o <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start && vec_valid_i) begin
            input_to_uut_1_o <= vec1_i;
            input_to_uut_2_o <= vec2_i;
            done_o           <= 1'b0;
            timeout_o        <= 1'b0;
            result_idx_o     <= '0;
            rst_uut_o        <= 1'b1;
            rst_cnt          <= '0;
            state            <= S_UUT_RST;
          end
        end
        S_UUT_RST: begin
          if (rst_cnt == RST_LAST) begin
            rst_uut_o <= 1'b0;
            run_cnt   <= '0;
            state     <= S_RUN;
          end else begin
            rst_cnt <= rst_cnt + 32'd1;
          end
        end
        S_RUN: begin
          // a capture on the final counted cycle wins over the timeout
          if (end_rise) begin
            result_data_o  <= uut_data_i;
            result_valid_o <= 1'b1;
`ifdef SEQ_CYCLE_COUNT_EN
            cycle_count_q  <= run_cnt;
`endif
            state          <= S_HOLD;
          end else if (run_cnt == TO_LAST) begin
            timeout_o <= 1'b1;
            rst_uut_o <= 1'b1;
            state     <= S_ERR;
          end else begin
            run_cnt <= run_cnt + 32'd1;
          end
        end
        S_HOLD: begin
          if (result_ready_i) begin
            result_valid_o <= 1'b0;
            if (result_idx_o == IDX_LAST) begin
              done_o    <= 1'b1;
              rst_uut_o <= 1'b1;
              state     <= S_DONE;
            end else begin
              result_idx_o <= result_idx_o + 8'd1;
              next_data_o  <= 1'b1;
              run_cnt      <= '0;
              state        <= S_RUN;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // zero-extend so narrow OUT_W still yields a defined upper debug word
  logic [63:0] data_ext;
  if (OUT_W >= 64) begin : g_wide
    assign data_ext = result_data_o[63:0];
  end else begin : g_narrow
    assign data_ext = 64'(result_data_o);
  end

  always_comb begin
    debug_o = 32'd0;
    case (sw_debug_i)
      2'd0: debug_o = data_ext[31:0];
      2'd1: debug_o = data_ext[63:32];
      2'd2: debug_o = {13'd0, state, result_idx_o, 2'b00, next_data_o, rst_uut_o,
                       result_valid_o, timeout_o, done_o, busy_o};
      2'd3: debug_o = cycle_count_o;
    endcase
  end

endmodule

// File: doc/stream_test_sequencer.md
STREAM_TEST_SEQUENCER -- requirements
Module: stream_test_sequencer

Interface
REQ-001 SHALL have parameter IN1_W, default 80, width of UUT input vector 1 (IV).
REQ-002 SHALL have parameter IN2_W, default 80, width of UUT input vector 2 (key).
REQ-003 SHALL have parameter OUT_W, default 64, width of one UUT output block.
REQ-004 SHALL have parameter NUM_BLOCKS, default 4 (1..256), output blocks captured per run.
REQ-005 SHALL have parameter RST_CYCLES, default 4 (>=1), UUT reset pulse length.
REQ-006 SHALL have parameter TIMEOUT, default 65535, max cycles waiting for each block.
REQ-007 SHALL have ports, clock and reset first:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin run (level sampled per cycle)
- vec1_i  in  IN1_W  input vector 1 from loader
- vec2_i  in  IN2_W  input vector 2 from loader
- vec_valid_i  in  1  vectors valid
- rst_uut_o  out  1  active-high UUT reset
- input_to_uut_1_o  out  IN1_W  latched vector 1
- input_to_uut_2_o  out  IN2_W  latched vector 2
- next_data_o  out  1  one-cycle request for next UUT block
- end_uut_i  in  1  UUT block-ready flag
- uut_data_i  in  OUT_W  UUT output block
- result_valid_o  out  1  captured block valid
- result_data_o  out  OUT_W  captured block
- result_idx_o  out  8  block index 0..NUM_BLOCKS-1
- result_ready_i  in  1  consumer accepts block
- busy_o  out  1  run in progress
- done_o  out  1  run completed
- timeout_o  out  1  run aborted on timeout
- cycle_count_o  out  32  UUT cycles of last block
- sw_debug_i  in  2  debug mux select
- debug_o  out  32  debug word

Function
REQ-008 SHALL implement states IDLE, UUT_RST, RUN, HOLD, DONE, ERR.
REQ-009 In IDLE/DONE/ERR, start=1 with vec_valid_i=1 SHALL latch vec1_i/vec2_i into input_to_uut_*_o, clear done_o/timeout_o/result_idx_o, enter UUT_RST; start without vec_valid_i SHALL be ignored.
REQ-010 UUT_RST SHALL hold rst_uut_o=1 for exactly RST_CYCLES cycles, then enter RUN with rst_uut_o=0.
REQ-011 RUN SHALL detect rising edge of end_uut_i (registered previous value); on edge, uut_data_i SHALL be registered into result_data_o, result_valid_o=1 next cycle, enter HOLD.
REQ-012 RUN SHALL count cycles from entry; counter reaching TIMEOUT without edge SHALL enter ERR, timeout_o=1, rst_uut_o=1.
REQ-013 HOLD: result_valid_o, result_data_o, result_idx_o SHALL remain stable until result_ready_i=1; valid SHALL NOT depend combinationally on ready.
REQ-014 On accept with result_idx_o<NUM_BLOCKS-1: result_valid_o=0, result_idx_o+1, next_data_o pulsed one cycle, re-enter RUN with counter cleared.
REQ-015 On accept with result_idx_o=NUM_BLOCKS-1: enter DONE, done_o=1, rst_uut_o=1.
REQ-016 busy_o SHALL be 1 in UUT_RST, RUN, HOLD; start while busy_o=1 SHALL be ignored.
REQ-017 end_uut_i already high on RUN entry SHALL NOT count as an edge.
REQ-018 debug_o by sw_debug_i: 0 result_data_o[31:0], 1 result_data_o[63:32] (zero if OUT_W<=32), 2 {state,result_idx_o,flags}, 3 cycle_count_o.

Reset
REQ-019 rst_n=0 SHALL immediately force IDLE, rst_uut_o=1, all other outputs and registers 0.
REQ-020 Reset deassertion mid-run SHALL NOT resume; a new start is required.

Configuration
REQ-021 With SEQ_CYCLE_COUNT_EN defined, cycle_count_o SHALL load the RUN counter value on each edge capture; without it, cycle_count_o SHALL be constant 0 and debug select 3 SHALL return 0.

Verification
REQ-022 Bench SHALL cover:
- vec_valid_i=1, start pulse, model asserts end_uut_i 10 cycles after reset release, NUM_BLOCKS=4, ready always 1 -> indices 0..3, 3 next_data_o pulses, done_o=1, cycle_count_o=10.
- ready held 0 for 20 cycles in HOLD -> result_data_o/result_idx_o stable, no next_data_o.
- TIMEOUT=100, end_uut_i never rises -> ERR at cycle 100, timeout_o=1, rst_uut_o=1, busy_o=0.
- start with vec_valid_i=0 -> stays IDLE; start pulse mid-RUN -> ignored.
- rst_n low during HOLD -> IDLE next edge-independent, all outputs 0, rst_uut_o=1.
- RST_CYCLES=4 -> rst_uut_o high exactly 4 cycles after start.
